// File: rtl/i2s_master_tx.sv
// ---------------------------------------------------------------------------
// i2s_master_tx
//
// I2S bus master transmitter for the DAC side of a WM8731 codec. BCLK and
// LRCLK are derived from the system clock by division. One stereo pair is
// accepted at a time through a single-entry holding register and serialised
// MSB-first in standard I2S framing: one BCLK of delay after each LRCLK edge,
// left channel while LRCLK is low.
//
// Configuration macro:
//   UNDERRUN_HOLD_EN  when defined, an underrun frame repeats the last pair
//                     that was transmitted; when undefined it sends silence.
//
// Ports:
//   clk            system clock, all logic on its rising edge
//   reset_n        synchronous active-low reset
//   i_left_data    left-channel sample (two's complement, passed bit-exact)
//   i_right_data   right-channel sample (two's complement, passed bit-exact)
//   i_valid        sample pair on the data inputs is valid
//   o_ready        holding register empty; pair taken when i_valid && o_ready
//   bclk           bit clock to codec, period 2*CLK_DIV clk cycles
//   lrclk          word select, 0 = left slot, 1 = right slot
//   sdata_out      serial data, changes on BCLK falling edges
//   o_frame_start  one-clk pulse when a frame's data enters the shifters
//   o_underrun     one-clk pulse when a frame starts with nothing held
// ---------------------------------------------------------------------------
module i2s_master_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] i_left_data,
    input  logic [DATA_WIDTH-1:0] i_right_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata_out,
    output logic                  o_frame_start,
    output logic                  o_underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    logic [DIV_W-1:0]      r_div;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_slot;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;
    logic [DATA_WIDTH-1:0] r_shift_l;
    logic [DATA_WIDTH-1:0] r_shift_r;
    logic                  r_frame_start;
    logic                  r_underrun;

    logic                  w_div_wrap;
    logic                  w_fall_tick;
    logic                  w_frame_start;
    logic                  w_accept;
    logic                  w_data_bit;
    logic [DATA_WIDTH-1:0] w_fill_l;
    logic [DATA_WIDTH-1:0] w_fill_r;

`ifdef UNDERRUN_HOLD_EN
    logic [DATA_WIDTH-1:0] r_last_l;
    logic [DATA_WIDTH-1:0] r_last_r;

    assign w_fill_l = r_last_l;
    assign w_fill_r = r_last_r;
`else
    assign w_fill_l = '0;
    assign w_fill_r = '0;
`endif

    assign w_div_wrap    = (r_div == DIV_W'(CLK_DIV - 1));
    // The falling tick is the divider wrap while bclk is high: bclk drops
    // on this very edge, so data changes half a BCLK before the codec samples.
    assign w_fall_tick   = w_div_wrap & r_bclk;
    // r_slot/r_bit name the bit position driven at the next falling tick.
    assign w_frame_start = w_fall_tick & ~r_slot & (r_bit == '0);
    assign w_accept      = i_valid & ~r_hold_full;
    assign w_data_bit    = (r_bit != '0) && (r_bit <= BIT_W'(DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: data registers are reset too; a mid-stream reset must
            // discard the held pair and return sdata_out to a known 0.
            r_div         <= '0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_slot        <= 1'b0;
            r_bit         <= '0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_shift_l     <= '0;
            r_shift_r     <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
            r_last_l      <= '0;
            r_last_r      <= '0;
`endif
        end else begin
            // NOTE: pulses default low every clk and are only raised below,
            // which makes them exactly one clk wide.
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (w_div_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div  <= r_div + DIV_W'(1);
            end

            if (w_fall_tick) begin
                r_lrclk <= r_slot;

                if (r_bit == BIT_W'(SLOT_WIDTH - 1)) begin
                    r_bit  <= '0;
                    r_slot <= ~r_slot;
                end else begin
                    r_bit  <= r_bit + BIT_W'(1);
                end

                if (w_frame_start) begin
                    // Both channels load together; the right word is never
                    // re-read from the holding register at the slot change.
                    r_sdata       <= 1'b0;
                    r_frame_start <= 1'b1;
                    if (r_hold_full) begin
                        r_shift_l   <= r_hold_l;
                        r_shift_r   <= r_hold_r;
                        r_hold_full <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
                        r_last_l    <= r_hold_l;
                        r_last_r    <= r_hold_r;
`endif
                    end else begin
                        r_shift_l  <= w_fill_l;
                        r_shift_r  <= w_fill_r;
                        r_underrun <= 1'b1;
                    end
                end else if (w_data_bit) begin
                    if (r_slot) begin
                        r_sdata   <= r_shift_r[DATA_WIDTH-1];
                        r_shift_r <= r_shift_r << 1;
                    end else begin
                        r_sdata   <= r_shift_l[DATA_WIDTH-1];
                        r_shift_l <= r_shift_l << 1;
                    end
                end else begin
                    // One-bit I2S delay at b=0 and padding after the LSB.
                    r_sdata <= 1'b0;
                end
            end

            // Accept is only possible while empty, so it never collides with
            // the load above clearing r_hold_full. An accept on an underrun
            // tick lands here and waits for the following frame.
            if (w_accept) begin
                r_hold_l    <= i_left_data;
                r_hold_r    <= i_right_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign o_ready       = ~r_hold_full;
    assign bclk          = r_bclk;
    assign lrclk         = r_lrclk;
    assign sdata_out     = r_sdata;
    assign o_frame_start = r_frame_start;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_tx
//
// Self-checking bench for i2s_master_tx. Accepted pairs are pushed into a
// scoreboard queue tagged with the clk edge that took them; a monitor on the
// falling clk edge predicts every output from the number of clk edges since
// reset release using plain arithmetic (BCLK phase, frame position, slot and
// bit index) and pops the queue at each predicted frame start.
// Honours UNDERRUN_HOLD_EN for the expected underrun payload.
// ---------------------------------------------------------------------------
module tb_i2s_master_tx;

    localparam int DW = 24;
    localparam int SW = 32;
    localparam int CD = 4;
    localparam int TICK_CLKS  = 2 * CD;
    localparam int FRAME_CLKS = 2 * SW * TICK_CLKS;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            cyc;
    } acc_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] i_left_data;
    logic [DW-1:0] i_right_data;
    logic          i_valid;
    logic          o_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata_out;
    logic          o_frame_start;
    logic          o_underrun;

    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;   // clk edges since reset release
    bit   mon_en   = 1'b0;
    acc_t q[$];

    // Reference model state for the frame on the wire.
    logic [DW-1:0] cur_l  = '0;
    logic [DW-1:0] cur_r  = '0;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;

    i2s_master_tx #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .CLK_DIV   (CD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_left_data  (i_left_data),
        .i_right_data (i_right_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata_out    (sdata_out),
        .o_frame_start(o_frame_start),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: wait bound expired at n=%0d", name, n);
    endtask

    // Edge counter and reset-side model flush.
    always @(posedge clk) begin
        if (!reset_n) begin
            n = 0;
            q.delete();
            cur_l  = '0;
            cur_r  = '0;
            last_l = '0;
            last_r = '0;
        end else begin
            n = n + 1;
        end
    end

    // Monitor: predicts outputs after edge n, then records any accept that
    // the coming edge n+1 will perform.
    int            k, p, s, b;
    logic          exp_bclk, exp_lr, exp_sd, exp_fs, exp_ur;
    logic [DW-1:0] word;
    acc_t          ent;

    always @(negedge clk) begin
        if (mon_en) begin
            if (n == 0) begin
                check("rst_bclk",  bclk,          1'b0);
                check("rst_lrclk", lrclk,         1'b0);
                check("rst_sdata", sdata_out,     1'b0);
                check("rst_ready", o_ready,       1'b1);
                check("rst_fs",    o_frame_start, 1'b0);
                check("rst_ur",    o_underrun,    1'b0);
            end else begin
                exp_bclk = ((n / CD) % 2) == 1;
                exp_lr   = 1'b0;
                exp_sd   = 1'b0;
                exp_fs   = 1'b0;
                exp_ur   = 1'b0;
                if (n >= TICK_CLKS) begin
                    k = n / TICK_CLKS - 1;
                    p = k % (2 * SW);
                    if ((n % TICK_CLKS) == 0 && p == 0) begin
                        exp_fs = 1'b1;
                        if (q.size() != 0 && q[0].cyc < n) begin
                            ent    = q.pop_front();
                            cur_l  = ent.l;
                            cur_r  = ent.r;
                            last_l = ent.l;
                            last_r = ent.r;
                        end else begin
                            exp_ur = 1'b1;
`ifdef UNDERRUN_HOLD_EN
                            cur_l = last_l;
                            cur_r = last_r;
`else
                            cur_l = '0;
                            cur_r = '0;
`endif
                        end
                    end
                    s      = p / SW;
                    b      = p % SW;
                    exp_lr = (s == 1);
                    word   = (s == 1) ? cur_r : cur_l;
                    if (b >= 1 && b <= DW) exp_sd = word[DW-b];
                end
                check("bclk",        bclk,          exp_bclk);
                check("lrclk",       lrclk,         exp_lr);
                check("sdata_out",   sdata_out,     exp_sd);
                check("frame_start", o_frame_start, exp_fs);
                check("underrun",    o_underrun,    exp_ur);
                check("ready",       o_ready,       q.size() == 0);
            end
            if (reset_n === 1'b1 && i_valid === 1'b1 && o_ready === 1'b1) begin
                ent.l   = i_left_data;
                ent.r   = i_right_data;
                ent.cyc = n + 1;
                q.push_back(ent);
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int waited = 0;
        bit done   = 1'b0;
        i_left_data  = l;
        i_right_data = r;
        i_valid      = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                waited = waited + 1;
                if (waited > 2 * FRAME_CLKS) begin
                    timeout_fail("send");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [31:0] rl, rr;

    initial begin
        reset_n      = 1'b0;
        i_valid      = 1'b0;
        i_left_data  = '0;
        i_right_data = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Nothing offered: the first frame start at clk 8 is an underrun.
        idle(40);

        // Pair ready before the first frame start, then a second pair
        // back-to-back that must wait for that frame start.
        pulse_reset();
        send(24'hA5F00F, 24'h123456);
        rl = $urandom();
        rr = $urandom();
        send(rl[DW-1:0], rr[DW-1:0]);
        // Second frame carries the held pair, third frame underruns.
        idle(2 * FRAME_CLKS + 100);

        // Sign-boundary patterns.
        send(24'h800000, 24'h7FFFFF);
        idle(FRAME_CLKS + 50);

        // Random pairs with random gaps, some long enough to underrun.
        for (int i = 0; i < 6; i++) begin
            rl = $urandom();
            rr = $urandom();
            send(rl[DW-1:0], rr[DW-1:0]);
            idle($urandom_range(0, FRAME_CLKS + 200));
        end

        // Reset in the right slot (s=1, b=10) with a pair still held.
        rl = $urandom();
        rr = $urandom();
        send(rl[DW-1:0], rr[DW-1:0]);
        rl = $urandom();
        rr = $urandom();
        send(rl[DW-1:0], rr[DW-1:0]);
        begin
            int  waited = 0;
            bit  hit    = 1'b0;
            while (!hit && waited < 2 * FRAME_CLKS) begin
                if ((n % FRAME_CLKS) == (SW + 10) * TICK_CLKS + 3) hit = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                    waited = waited + 1;
                end
            end
            if (!hit) timeout_fail("mid_frame_wait");
        end
        pulse_reset();
        idle(FRAME_CLKS + 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S bus master transmitter that drives the DAC side of the WM8731 codec.
- Runs on the FPGA system clock and generates BCLK and LRCLK by division.
- Accepts one stereo sample pair at a time over a valid/ready handshake and serialises it MSB-first in standard I2S framing: one BCLK delay after each LRCLK edge, left channel while LRCLK is low.
- It is the transmit-direction counterpart of the I2S receive path and feeds processed or test audio back to the codec.

Parameters:
- DATA_WIDTH, 24, bits per audio sample per channel.
- SLOT_WIDTH, 32, BCLK periods per channel slot; legal when SLOT_WIDTH >= DATA_WIDTH+1.
- CLK_DIV, 4, clk cycles per BCLK half-period; legal when CLK_DIV >= 2.

Ports:
- clk  input  1  system clock; all logic is on posedge clk.
- reset_n  input  1  synchronous, active-low reset.
- i_left_data  input  DATA_WIDTH  left-channel sample, two's complement.
- i_right_data  input  DATA_WIDTH  right-channel sample, two's complement.
- i_valid  input  1  sample pair on i_left_data/i_right_data is valid.
- o_ready  output  1  holding register is empty; the pair is accepted on a clk edge where i_valid && o_ready.
- bclk  output  1  bit clock to codec; period 2*CLK_DIV clk cycles.
- lrclk  output  1  word select to codec; 0 = left slot, 1 = right slot.
- sdata_out  output  1  serial data to codec DAC.
- o_frame_start  output  1  one-clk pulse when a new frame's data is loaded into the shifter.
- o_underrun  output  1  one-clk pulse when a frame starts with the holding register empty.

Behaviour:
- Clock and reset: one clock (clk). reset_n is synchronous and active-low; it is sampled on posedge clk.
- Reset values: bclk=0, lrclk=0, sdata_out=0, o_ready=1, o_frame_start=0, o_underrun=0. Divider, bit and slot counters=0; holding register empty; shifters=0; last-sample register=0.
- Divider: counter runs 0..CLK_DIV-1. On wrap, bclk toggles.
  - First rising edge of bclk: CLK_DIV clks after reset release.
  - First falling edge: 2*CLK_DIV clks after reset release.
- Falling-edge tick: the clk cycle where bclk goes 1->0. All of the following update only on this tick:
  - bit counter b, range 0..SLOT_WIDTH-1;
  - slot counter s, range 0..1;
  - lrclk, sdata_out, and the shifters.
  - The codec samples sdata_out on the bclk rising edge.
- Framing: lrclk = s. Within each slot, sdata_out is:
  - 0 at b=0 (the I2S one-bit delay);
  - data bits MSB..LSB for b=1..DATA_WIDTH;
  - 0 for b=DATA_WIDTH+1..SLOT_WIDTH-1.
  - Frame = 2*SLOT_WIDTH BCLK periods. The slot counter wraps from (s=1, b=SLOT_WIDTH-1) to (s=0, b=0).
- Frame start: the first falling tick after reset, and every tick with s=0, b=0.
  - If the holding register is full: copy left and right into the shifters (both channels together), mark holding empty, and pulse o_frame_start.
  - If it is empty: pulse o_frame_start and o_underrun, and load the underrun data (see Optional Feature).
  - The right-channel word is taken from the frame-start load; it is never re-read at s=1.
- Handshake:
  - o_ready = !holding_full.
  - An accept in the same clk as a frame-start tick with holding empty goes into the holding register for the next frame. That frame start still counts as an underrun; the load uses pre-edge state.
  - No accept is possible while holding is full. Holding depth gives a maximum of one pair of lookahead.
- Data path: no arithmetic. Samples pass bit-exact; no truncation or sign handling.
- Reset mid-operation: the next clk after reset_n=0 sampled, all outputs and state take their reset values and any held sample is discarded.

Optional Feature:
- Macro: UNDERRUN_HOLD_EN.
- Defined: on underrun, the last successfully transmitted pair (kept in a last-sample register, 0 after reset) is retransmitted.
- Undefined: on underrun, both slots transmit all zeros (silence). No last-sample register is instantiated.
- o_underrun pulses in both builds.

Test Plan:
Defaults DATA_WIDTH=24, SLOT_WIDTH=32, CLK_DIV=4 (BCLK = 8 clk, frame = 512 clk).
1. Reset release -> all outputs at reset values. bclk rises at clk 4 and falls at clk 8. The first frame start is at clk 8, with an o_underrun pulse if nothing was accepted.
2. Accept L=24'hA5F00F, R=24'h123456 before the first frame start:
   - left slot: lrclk=0, sdata_out=0 at b=0, bits of A5F00F MSB-first at b=1..24, 0 at b=25..31;
   - right slot: same pattern with lrclk=1 and 123456;
   - o_frame_start pulses once and o_underrun stays 0.
3. Hold i_valid high with two pairs back-to-back -> first accepted immediately, then o_ready=0. The second is accepted the clk after the next frame start and is transmitted in the following frame.
4. No input after one frame -> o_underrun pulses at the next frame start:
   - macro undefined: all-zero frame;
   - UNDERRUN_HOLD_EN: previous pair repeated.
5. Assert reset_n=0 for one clk at s=1, b=10 with a pair held -> next clk bclk=lrclk=sdata_out=0 and o_ready=1. After release, timing restarts per scenario 1.
6. L=24'h800000, R=24'h7FFFFF -> left b=1 is 1 and b=2..24 are 0. Right b=1 is 0 and b=2..24 are 1.
